// File: rtl/bbot_rc_pkg.sv
// Shared constants, state encoding and small helpers for the RC pulse decoders.
package bbot_rc_pkg;

    localparam int unsigned RC_LOW_LIMIT_PULSES  = 32'd50000;
    localparam int unsigned RC_ZERO_POINT_PULSES = 32'd75000;
    localparam int unsigned RC_RANGE_MULT        = 32'd250;
    localparam int unsigned RC_MIN_VALID_PULSES  = 32'd40000;
    localparam int unsigned RC_MAX_VALID_PULSES  = 32'd110000;
    localparam int unsigned RC_TIMEOUT_PULSES    = 32'd2200000;
    localparam int unsigned RC_PERIOD_PULSES     = 32'd1100000;
    localparam int unsigned RC_PERCENT_MAX       = 32'd200;
    localparam int unsigned RC_PERCENT_W         = 32'd8;

    localparam logic [RC_PERCENT_W-1:0] RC_PERCENT_NEUTRAL = 8'd100;
    localparam logic [RC_PERCENT_W-1:0] RC_PERCENT_SAT     = 8'd200;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        OVERLONG  = 2'd3
    } rc_state_e;

    // Saturating increment used by the free-running timeout counter.
    function automatic logic [31:0] rc_sat_inc(input logic [31:0] v, input logic [31:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/bbot_input_sync.sv
// Two-flop synchronizer with an edge-detect flop; ready_o marks when the
// synchronized value reflects a real sample taken after reset release.
module bbot_input_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o,
    output logic ready_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;

    // Synchronizer chain plus fill tracker
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 2'b00;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    assign sync_o  = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;
    assign ready_o = fill_q[1];

endmodule

// File: rtl/bbot_rc_pulse_decoder.sv
// Measures one RC servo pulse width and converts it to the 0..200 percent
// scale (100 = neutral), with fail-safe neutral output on signal loss.
module bbot_rc_pulse_decoder
    import bbot_rc_pkg::*;
#(
    parameter int unsigned LOW_LIMIT  = RC_LOW_LIMIT_PULSES,
    parameter int unsigned ZERO_POINT = RC_ZERO_POINT_PULSES,
    parameter int unsigned RANGE_MULT = RC_RANGE_MULT,
    parameter int unsigned MIN_VALID  = RC_MIN_VALID_PULSES,
    parameter int unsigned MAX_VALID  = RC_MAX_VALID_PULSES,
    parameter int unsigned TIMEOUT    = RC_TIMEOUT_PULSES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rc_in,
    output logic [31:0]             pulse_width,
    output logic [RC_PERCENT_W-1:0] percent,
    output logic                    new_sample,
    output logic                    valid,
    output logic                    signal_lost,
    output logic                    bad_pulse
);

    logic sync_s, rise_s, fall_s, ready_s;

    bbot_input_sync u_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (rc_in),
        .sync_o  (sync_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s),
        .ready_o (ready_s)
    );

    rc_state_e               state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             pre_q, pre_d;
    logic [RC_PERCENT_W-1:0] acc_q, acc_d;
    logic [31:0]             to_q, to_d;
    logic [31:0]             pw_q, pw_d;
    logic [RC_PERCENT_W-1:0] pct_q, pct_d;
    logic                    ns_q, ns_d;
    logic                    valid_q, valid_d;
    logic                    lost_q, lost_d;
    logic                    bad_q, bad_d;
    logic                    accept_s;

    // Next-state, measurement and output update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        acc_d    = acc_q;
        pw_d     = pw_q;
        pct_d    = pct_q;
        ns_d     = 1'b0;
        bad_d    = 1'b0;
        valid_d  = valid_q;
        lost_d   = lost_q;
        accept_s = 1'b0;
        to_d     = rc_sat_inc(to_q, TIMEOUT);

        case (state_q)
            WAIT_LOW: begin
                // Reset-cleared sync flops read low; only trust them once filled.
                if (ready_s && !sync_s) begin
                    state_d = WAIT_RISE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_RISE: begin
                if (rise_s) begin
                    cnt_d   = 32'd1;
                    pre_d   = 32'd0;
                    acc_d   = 8'd0;
                    state_d = HIGH;
                end else begin
                    state_d = WAIT_RISE;
                end
            end
            HIGH: begin
                if (fall_s) begin
                    if (cnt_q < MIN_VALID) begin
                        bad_d = 1'b1;
                    end else begin
                        accept_s = 1'b1;
                    end
                    state_d = WAIT_RISE;
                end else if (cnt_q >= MAX_VALID) begin
                    state_d = OVERLONG;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    // acc tracks floor((cnt - LOW_LIMIT) / RANGE_MULT) without a divider
                    if (cnt_q >= LOW_LIMIT) begin
                        if (pre_q == RANGE_MULT - 32'd1) begin
                            pre_d = 32'd0;
                            if (acc_q == RC_PERCENT_SAT) begin
                                acc_d = acc_q;
                            end else begin
                                acc_d = acc_q + 8'd1;
                            end
                        end else begin
                            pre_d = pre_q + 32'd1;
                        end
                    end else begin
                        pre_d = pre_q;
                    end
                end
            end
            OVERLONG: begin
                if (fall_s) begin
                    bad_d   = 1'b1;
                    state_d = WAIT_RISE;
                end else begin
                    state_d = OVERLONG;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase

        // An accepted pulse takes priority over a timeout expiring on the same edge.
        if (accept_s) begin
            pw_d    = cnt_q;
            pct_d   = acc_q;
            ns_d    = 1'b1;
            valid_d = 1'b1;
            lost_d  = 1'b0;
            to_d    = 32'd0;
        end else if (to_q == TIMEOUT - 32'd1) begin
            pw_d    = ZERO_POINT;
            pct_d   = RC_PERCENT_NEUTRAL;
            valid_d = 1'b0;
            lost_d  = 1'b1;
        end else begin
            pw_d = pw_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            cnt_q   <= 32'd0;
            pre_q   <= 32'd0;
            acc_q   <= 8'd0;
            to_q    <= 32'd0;
            pw_q    <= ZERO_POINT;
            pct_q   <= RC_PERCENT_NEUTRAL;
            ns_q    <= 1'b0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            acc_q   <= acc_d;
            to_q    <= to_d;
            pw_q    <= pw_d;
            pct_q   <= pct_d;
            ns_q    <= ns_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
            bad_q   <= bad_d;
        end
    end

    assign pulse_width = pw_q;
    assign percent     = pct_q;
    assign new_sample  = ns_q;
    assign valid       = valid_q;
    assign signal_lost = lost_q;
    assign bad_pulse   = bad_q;

endmodule
